ga_sync_irq: RTL and testbench



---
 rtl/ga_sync_irq.sv | 93 +++++++++
 tb/tb_ga_sync_irq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ga_sync_irq.sv
// ga_sync_irq: CPC Gate Array sync reshaping, 52-line raster interrupt and screen mode latch.
// Define GA_MODE_HSYNC_LATCH_EN to defer mode writes to the next CRTC HSYNC rise.
module ga_sync_irq #(
   parameter int HS_DELAY = 2,
   parameter int HS_WIDTH = 4,
   parameter int VS_LINES = 26
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       CLKEN,
   input  logic       CRTC_HSYNC,
   input  logic       CRTC_VSYNC,
   input  logic       INT_ACK,
   input  logic       IRQ_CLR,
   input  logic       MODE_WR,
   input  logic [1:0] MODE_DI,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       IRQ,
   output logic [1:0] MODE,
   output logic [5:0] INT_CNT
);
   localparam int VW = $clog2(VS_LINES + 1);
   logic          hs_prev, vs_prev;
   logic [2:0]    hcnt, hcnt_n;
   logic [VW-1:0] vcnt, vcnt_n;
   logic [1:0]    vs_dly, vs_dly_n;
   logic          hs_rise, hs_fall, vs_rise, raise, irq_n;
   logic [5:0]    cnt_inc, cnt_r52, cnt_n;

   always_comb begin
      hs_rise  = CLKEN & CRTC_HSYNC & ~hs_prev;
      hs_fall  = CLKEN & ~CRTC_HSYNC & hs_prev;
      vs_rise  = CLKEN & CRTC_VSYNC & ~vs_prev;
      hcnt_n   = CRTC_HSYNC ? ((hcnt == 3'd7) ? hcnt : hcnt + 3'd1) : 3'd0;
      vcnt_n   = vs_rise ? VW'(VS_LINES) : (hs_fall && vcnt != '0) ? vcnt - VW'(1) : vcnt;
      vs_dly_n = vs_rise ? 2'd2 : (hs_fall && vs_dly != 2'd0) ? vs_dly - 2'd1 : vs_dly;
      cnt_inc  = INT_CNT + 6'd1;
      // The second line after a VSYNC rise resynchronises the 52-line counter
      raise    = hs_fall & ((vs_dly == 2'd1) ? (INT_CNT >= 6'd32) : (cnt_inc == 6'd52));
      cnt_r52  = !hs_fall ? INT_CNT : (vs_dly == 2'd1 || cnt_inc == 6'd52) ? 6'd0 : cnt_inc;
      cnt_n    = IRQ_CLR ? 6'd0 : INT_ACK ? (cnt_r52 & 6'h1F) : cnt_r52;
      irq_n    = ~IRQ_CLR & (INT_ACK ? raise : (IRQ | raise));
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
         hcnt    <= 3'd0;
         HSYNC   <= 1'b0;
         vcnt    <= '0;
         VSYNC   <= 1'b0;
         vs_dly  <= 2'd0;
         INT_CNT <= 6'd0;
         IRQ     <= 1'b0;
      end else begin
         if (CLKEN) begin
            hs_prev <= CRTC_HSYNC;
            vs_prev <= CRTC_VSYNC;
            hcnt    <= hcnt_n;
            HSYNC   <= (int'(hcnt_n) > HS_DELAY) && (int'(hcnt_n) <= HS_DELAY + HS_WIDTH);
         end
         vcnt    <= vcnt_n;
         VSYNC   <= vcnt_n != '0;
         vs_dly  <= vs_dly_n;
         INT_CNT <= cnt_n;
         IRQ     <= irq_n;
      end
   end

`ifdef GA_MODE_HSYNC_LATCH_EN
   logic [1:0] pending;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pending <= 2'd0;
         MODE    <= 2'd0;
      end else begin
         if (MODE_WR) pending <= MODE_DI;
         if (hs_rise) MODE <= pending;
      end
   end
`else
   logic unused_rise;
   assign unused_rise = hs_rise;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) MODE <= 2'd0;
      else if (MODE_WR) MODE <= MODE_DI;
   end
`endif
endmodule

// File: tb/tb_ga_sync_irq.sv
// tb_ga_sync_irq: scoreboard bench for ga_sync_irq against a line-level behavioural model.
module tb_ga_sync_irq;
   localparam int HS_DELAY = 2, HS_WIDTH = 4, VS_LINES = 26;
   typedef logic [10:0] exp_t;

   logic       CLOCK = 0, RESET = 1, CLKEN = 0, CRTC_HSYNC = 0, CRTC_VSYNC = 0;
   logic       INT_ACK = 0, IRQ_CLR = 0, MODE_WR = 0;
   logic [1:0] MODE_DI = 0;
   logic       HSYNC, VSYNC, IRQ;
   logic [1:0] MODE;
   logic [5:0] INT_CNT;

   ga_sync_irq #(.HS_DELAY(HS_DELAY), .HS_WIDTH(HS_WIDTH), .VS_LINES(VS_LINES)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .CLKEN(CLKEN), .CRTC_HSYNC(CRTC_HSYNC),
      .CRTC_VSYNC(CRTC_VSYNC), .INT_ACK(INT_ACK), .IRQ_CLR(IRQ_CLR), .MODE_WR(MODE_WR),
      .MODE_DI(MODE_DI), .HSYNC(HSYNC), .VSYNC(VSYNC), .IRQ(IRQ), .MODE(MODE), .INT_CNT(INT_CNT)
   );

   always #5 CLOCK = ~CLOCK;

   exp_t q[$];
   exp_t mon_e, mon_a;
   int   checks = 0, passed = 0;
   bit   rnd_en = 0;

   // Reference model: chars since HSYNC rise, lines left in VSYNC, falls since VSYNC rise
   int       m_run, m_left, m_arm, m_cnt;
   bit       m_hsp, m_vsp, m_irq, m_hs;
   logic [1:0] m_mode, m_pend;

   function automatic void m_reset();
      m_run = 0; m_left = 0; m_arm = -1; m_cnt = 0;
      m_hsp = 0; m_vsp = 0; m_irq = 0; m_hs = 0; m_mode = 0; m_pend = 0;
   endfunction

   function automatic void model(input bit ce, hs, vs, ack, clr, mwr, input logic [1:0] mdi);
      bit rh, fh, rv, raise;
      raise = 0;
      rh = ce && hs && !m_hsp;
      fh = ce && !hs && m_hsp;
      rv = ce && vs && !m_vsp;
      if (ce) begin
         m_run = hs ? m_run + 1 : 0;
         m_hs  = m_run > HS_DELAY && m_run <= HS_DELAY + HS_WIDTH;
         m_hsp = hs;
         m_vsp = vs;
      end
      if (fh) begin
         if (m_left > 0) m_left--;
         if (m_arm >= 0) m_arm++;
         if (m_arm == 2) begin
            raise = m_cnt >= 32;
            m_cnt = 0;
            m_arm = -1;
         end else begin
            m_cnt++;
            if (m_cnt == 52) begin
               m_cnt = 0;
               raise = 1;
            end
         end
      end
      if (rv) begin
         m_left = VS_LINES;
         m_arm  = 0;
      end
      if (clr) begin
         m_cnt = 0;
         m_irq = 0;
      end else if (ack) begin
         m_irq = raise;
         m_cnt = m_cnt % 32;
      end else m_irq = m_irq | raise;
`ifdef GA_MODE_HSYNC_LATCH_EN
      if (rh) m_mode = m_pend;
      if (mwr) m_pend = mdi;
`else
      if (mwr) m_mode = mdi;
`endif
   endfunction

   task automatic step(input bit ce, hs, vs, ack, clr, mwr, input logic [1:0] mdi);
      @(negedge CLOCK);
      CLKEN = ce; CRTC_HSYNC = hs; CRTC_VSYNC = vs;
      INT_ACK = ack; IRQ_CLR = clr; MODE_WR = mwr; MODE_DI = mdi;
      @(posedge CLOCK);
      #1;
      model(ce, hs, vs, ack, clr, mwr, mdi);
      q.push_back({m_hs, m_left != 0, m_irq, m_mode, 6'(m_cnt)});
      CLKEN = 0; INT_ACK = 0; IRQ_CLR = 0; MODE_WR = 0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // One raster line: CRTC HSYNC high on chars 1..w, falls on char w+1; CLKEN every other CLOCK
   task automatic line(input int w, input bit vs, input bit ack_f = 0, input bit clr_f = 0);
      for (int c = 0; c < 20; c++) begin
         bit hs, at_fall;
         hs = c >= 1 && c < 1 + w;
         at_fall = w > 0 && c == w + 1;
         step(1, hs, vs, (ack_f && at_fall) || (rnd_en && $urandom_range(63) == 0),
              (clr_f && at_fall) || (rnd_en && $urandom_range(127) == 0), 0, 0);
         step(0, hs, vs, rnd_en && $urandom_range(63) == 0, rnd_en && $urandom_range(127) == 0,
              rnd_en && $urandom_range(15) == 0, 2'($urandom_range(3)));
      end
   endtask

   task automatic lines(input int n, input bit vs = 0);
      for (int i = 0; i < n; i++) line(6, vs);
   endtask

   always @(negedge CLOCK) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         mon_a = {HSYNC, VSYNC, IRQ, MODE, INT_CNT};
         checks++;
         if (mon_a === mon_e) passed++;
         else $display("FAIL scoreboard t=%0t got hs=%b vs=%b irq=%b mode=%0d cnt=%0d expected hs=%b vs=%b irq=%b mode=%0d cnt=%0d",
                       $time, mon_a[10], mon_a[9], mon_a[8], mon_a[7:6], mon_a[5:0],
                       mon_e[10], mon_e[9], mon_e[8], mon_e[7:6], mon_e[5:0]);
      end
   end

   initial begin
      m_reset();
      #22;
      chk("reset_outputs", int'({HSYNC, VSYNC, IRQ, MODE, INT_CNT}), 0);
      @(negedge CLOCK);
      RESET = 0;
      line(14, 0);
      line(4, 0);
      line(2, 0);
      chk("cnt_after_3_lines", int'(INT_CNT), 3);
      step(0, 0, 0, 0, 1, 0, 0);
      lines(52);
      chk("irq_after_52", int'(IRQ), 1);
      chk("cnt_after_52", int'(INT_CNT), 0);
      lines(51);
      chk("irq_held_51", int'(IRQ), 1);
      chk("cnt_51", int'(INT_CNT), 51);
      lines(37);
      chk("cnt_36_pending", int'({IRQ, INT_CNT}), 64 + 36);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("ack_irq", int'(IRQ), 0);
      chk("ack_cnt", int'(INT_CNT), 4);
      lines(47);
      line(6, 0, 1, 0);
      chk("ack_on_52_irq", int'(IRQ), 1);
      chk("ack_on_52_cnt", int'(INT_CNT), 0);
      lines(51);
      line(6, 0, 0, 1);
      chk("clr_on_52", int'({IRQ, INT_CNT}), 0);
      lines(40);
      line(6, 1);
      line(6, 1);
      chk("vs_cnt40_irq", int'(IRQ), 1);
      chk("vs_cnt40_cnt", int'(INT_CNT), 0);
      lines(23);
      chk("vsync_25_lines", int'(VSYNC), 1);
      lines(1);
      chk("vsync_26_lines", int'(VSYNC), 0);
      step(0, 0, 0, 0, 1, 0, 0);
      lines(20);
      line(6, 1);
      line(6, 1);
      chk("vs_cnt20", int'({IRQ, INT_CNT}), 0);
      lines(24);
      line(6, 0);
      step(0, 1, 0, 0, 0, 1, 2);
`ifdef GA_MODE_HSYNC_LATCH_EN
      chk("mode_mid_line", int'(MODE), 0);
`else
      chk("mode_mid_line", int'(MODE), 2);
`endif
      line(6, 0);
      chk("mode_after_rise", int'(MODE), 2);
      line(6, 1);
      lines(3, 1);
      chk("mid_vsync", int'(VSYNC), 1);
      @(posedge CLOCK);
      #2;
      RESET = 1;
      #1;
      chk("async_reset", int'({HSYNC, VSYNC, IRQ, MODE, INT_CNT}), 0);
      m_reset();
      @(negedge CLOCK);
      RESET = 0;
      line(6, 0);
      chk("first_line_after_reset", int'(INT_CNT), 1);
      rnd_en = 1;
      for (int i = 0; i < 120; i++) begin
         int w = $urandom_range(15);
         line(w, (i % 40) >= 10 && (i % 40) < 13);
      end
      rnd_en = 0;
      repeat (3) @(negedge CLOCK);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
